// File: rtl/core_pkg.sv
// Shared LSU definitions: funct3 size/sign codes, FSM state encoding and
// the access-legality rule used when an instruction is accepted.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  // Unsigned sizes exist only for loads; halves and words must be naturally aligned.
  function automatic logic lsu_legal(input logic is_store, input logic [2:0] funct3,
                                     input logic [1:0] byte_off);
    logic ok;
    ok = 1'b0;
    case (funct3)
      LSU_B:   ok = 1'b1;
      LSU_H:   ok = ~byte_off[0];
      LSU_W:   ok = (byte_off == 2'b00);
      LSU_BU:  ok = ~is_store;
      LSU_HU:  ok = ~is_store & ~byte_off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads. Purely combinational.
module lsu_align
  import core_pkg::*;
(
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign load_byte = load_word[8*byte_off +: 8];
  assign load_half = byte_off[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (is_store) begin
      case (funct3)
        LSU_B: begin
          be    = 4'b0001 << byte_off;
          wdata = {4{store_data[7:0]}};
        end
        LSU_H: begin
          be    = byte_off[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    load_data = load_word;
    case (funct3)
      LSU_B:   load_data = {{24{load_byte[7]}}, load_byte};
      LSU_BU:  load_data = {24'h0, load_byte};
      LSU_H:   load_data = {{16{load_half[15]}}, load_half};
      LSU_HU:  load_data = {16'h0, load_half};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store, drives the req/gnt/rvalid data
// memory handshake, stalls the pipeline and returns extended load data.
module load_store_unit
  import core_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              lsu_stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              lsu_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_t state, state_next;

  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic              load_q;
  logic              err_q;
  logic [31:0]       wb_data_q;

  logic              accept;
  logic              legal;
  logic              in_req;
  logic [3:0]        be_al;
  logic [31:0]       wdata_al;
  logic [31:0]       load_al;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^ex_addr[31:ADDR_W+2];

  assign accept = (state == ST_IDLE) & ex_valid & (ex_load | ex_store);
  assign legal  = lsu_legal(ex_store, ex_funct3, ex_addr[1:0]);
  assign in_req = (state == ST_REQ);

  lsu_align u_align (
    .is_store   (~load_q),
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .store_data (wdata_q),
    .load_word  (dmem_rdata),
    .be         (be_al),
    .wdata      (wdata_al),
    .load_data  (load_al)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      funct3_q  <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q   <= ex_addr[ADDR_W+1:0];
        funct3_q <= ex_funct3;
        wdata_q  <= ex_wdata;
        rd_q     <= ex_rd;
        load_q   <= ex_load;
        err_q    <= ~legal;
      end
      if ((state == ST_WAIT) && dmem_rvalid) begin
        wb_data_q <= load_al;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = legal ? ST_REQ : ST_DONE;
      ST_REQ:  if (dmem_gnt) state_next = load_q ? ST_WAIT : ST_DONE;
      ST_WAIT: if (dmem_rvalid) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory-side outputs come straight from latched fields, so they stay stable until gnt.
  assign dmem_req   = in_req;
  assign dmem_we    = in_req & ~load_q;
  assign dmem_be    = in_req ? be_al : 4'b0000;
  assign dmem_addr  = in_req ? addr_q[ADDR_W+1:2] : '0;
  assign dmem_wdata = in_req ? wdata_al : 32'h0;

  assign lsu_stall = accept | (state == ST_REQ) | (state == ST_WAIT);
  assign wb_valid  = (state == ST_DONE) & load_q & ~err_q;
  assign lsu_err   = (state == ST_DONE) & err_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data memory whose
// grant and read-valid latency can be stretched per test.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_stall, wb_valid, lsu_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;

  logic [31:0] mem [0:1023];
  logic        mem_rvalid = 1'b0;
  logic        inj_rvalid = 1'b0;
  logic        pend = 1'b0;
  logic [9:0]  pend_addr = '0;
  int          gnt_cnt = 0;
  int          rv_cnt = 0;
  int          gnt_delay = 0;
  int          rvalid_delay = 0;

  int n_checks = 0;
  int n_fail = 0;

  int          r_done, r_stall, r_wb_cnt, r_err_cnt, r_req_cnt, r_after;
  logic        r_stable, r_we;
  logic [3:0]  r_be;
  logic [9:0]  r_addr;
  logic [31:0] r_wdata, r_wb_data;
  logic [4:0]  r_wb_rd;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_load     (ex_load),
    .ex_store    (ex_store),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_rd       (ex_rd),
    .lsu_stall   (lsu_stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .lsu_err     (lsu_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_be     (dmem_be),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  assign dmem_gnt    = dmem_req && (gnt_cnt >= gnt_delay);
  assign dmem_rvalid = mem_rvalid | inj_rvalid;

  // Memory model: grant after gnt_delay request cycles, data rvalid_delay cycles after the earliest slot.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (rst) begin
      gnt_cnt    <= 0;
      pend       <= 1'b0;
      rv_cnt     <= 0;
      dmem_rdata <= '0;
      mem[0]     <= 32'h8765_4321;
      mem[1]     <= 32'h0BAD_F00D;
    end else begin
      if (dmem_req && !dmem_gnt) gnt_cnt <= gnt_cnt + 1;
      if (dmem_req && dmem_gnt) begin
        gnt_cnt <= 0;
        if (dmem_we) begin
          for (int b = 0; b < 4; b++)
            if (dmem_be[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end else if (rvalid_delay == 0) begin
          mem_rvalid <= 1'b1;
          dmem_rdata <= mem[dmem_addr];
        end else begin
          pend      <= 1'b1;
          pend_addr <= dmem_addr;
          rv_cnt    <= 1;
        end
      end
      if (pend) begin
        if (rv_cnt == rvalid_delay) begin
          mem_rvalid <= 1'b1;
          dmem_rdata <= mem[pend_addr];
          pend       <= 1'b0;
        end else begin
          rv_cnt <= rv_cnt + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one instruction and records what happens until the DONE cycle, plus one cycle after.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [4:0] rd);
    int c;
    bit done;
    r_done = -1; r_stall = 0; r_wb_cnt = 0; r_err_cnt = 0; r_req_cnt = 0;
    r_stable = 1'b1; r_we = 1'b0; r_be = '0; r_addr = '0; r_wdata = '0;
    r_wb_data = '0; r_wb_rd = '0; r_after = 0;
    @(negedge clk);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    c = 0;
    done = 0;
    while (!done && c < 64) begin
      #1;
      c++;
      if (lsu_stall) r_stall++;
      if (wb_valid) begin
        r_wb_cnt++;
        r_wb_data = wb_data;
        r_wb_rd   = wb_rd;
      end
      if (lsu_err) r_err_cnt++;
      if (dmem_req) begin
        if (r_req_cnt == 0) begin
          r_be = dmem_be; r_we = dmem_we; r_addr = dmem_addr; r_wdata = dmem_wdata;
        end else if (dmem_be !== r_be || dmem_we !== r_we || dmem_addr !== r_addr ||
                     dmem_wdata !== r_wdata) begin
          r_stable = 1'b0;
        end
        r_req_cnt++;
      end
      if (!lsu_stall) begin
        done   = 1;
        r_done = c;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
      end
      @(negedge clk);
    end
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    #1;
    r_after = int'(wb_valid) + int'(lsu_err);
  endtask

  task automatic checkLoad(input string tag, input logic [31:0] exp_data, input logic [4:0] exp_rd);
    checkOutput({tag, "_data"}, r_wb_data, exp_data);
    checkOutput({tag, "_rd"}, {27'h0, r_wb_rd}, {27'h0, exp_rd});
    checkOutput({tag, "_pulses"}, r_wb_cnt, 1);
    checkOutput({tag, "_after"}, r_after, 0);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_ctrl", {26'h0, lsu_stall, wb_valid, lsu_err, dmem_req, dmem_we, 1'b0}, 32'h0);
    checkOutput("reset_wb", {wb_rd, wb_data[26:0]} | {5'h0, wb_data[31:27], 22'h0}, 32'h0);
    checkOutput("reset_mem", {18'h0, dmem_be, dmem_addr} | dmem_wdata, 32'h0);

    applyStimulus(1'b1, 1'b0, 3'b000, 32'd3, 32'h0, 5'd5);
    checkLoad("lb_a3", 32'hFFFF_FF87, 5'd5);
    checkOutput("lb_latency", r_done, 4);
    checkOutput("lb_stall", r_stall, 3);
    checkOutput("lb_be_we", {27'h0, r_we, r_be}, 32'h0000_000F);

    applyStimulus(1'b1, 1'b0, 3'b100, 32'd3, 32'h0, 5'd6);
    checkLoad("lbu_a3", 32'h0000_0087, 5'd6);

    applyStimulus(1'b1, 1'b0, 3'b001, 32'd2, 32'h0, 5'd7);
    checkLoad("lh_a2", 32'hFFFF_8765, 5'd7);

    applyStimulus(1'b1, 1'b0, 3'b101, 32'd0, 32'h0, 5'd8);
    checkLoad("lhu_a0", 32'h0000_4321, 5'd8);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'd4, 32'h0, 5'd9);
    checkLoad("lw_a4", 32'h0BAD_F00D, 5'd9);

    applyStimulus(1'b0, 1'b1, 3'b000, 32'd6, 32'h1234_56A5, 5'd0);
    checkOutput("sb_be", {28'h0, r_be}, 32'h4);
    checkOutput("sb_wdata", r_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_addr", {22'h0, r_addr}, 32'd1);
    checkOutput("sb_we", {31'h0, r_we}, 32'd1);
    checkOutput("sb_latency", r_done, 3);
    checkOutput("sb_stall", r_stall, 2);
    checkOutput("sb_no_strobe", r_wb_cnt + r_err_cnt, 0);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'd4, 32'h0, 5'd10);
    checkLoad("sb_readback", 32'h0BA5_F00D, 5'd10);

    applyStimulus(1'b0, 1'b1, 3'b001, 32'd2, 32'h5555_BEEF, 5'd0);
    checkOutput("sh_be", {28'h0, r_be}, 32'hC);
    checkOutput("sh_wdata", r_wdata, 32'hBEEF_BEEF);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'd0, 32'h0, 5'd11);
    checkLoad("sh_readback", 32'hBEEF_4321, 5'd11);

    gnt_delay = 3;
    rvalid_delay = 2;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'd4, 32'h0, 5'd12);
    checkLoad("slow_lw", 32'h0BA5_F00D, 5'd12);
    checkOutput("slow_req_cycles", r_req_cnt, 4);
    checkOutput("slow_stable", {31'h0, r_stable}, 32'd1);
    checkOutput("slow_addr", {22'h0, r_addr}, 32'd1);
    checkOutput("slow_latency", r_done, 9);
    checkOutput("slow_stall", r_stall, 8);
    gnt_delay = 0;
    rvalid_delay = 0;

    applyStimulus(1'b1, 1'b0, 3'b010, 32'd2, 32'h0, 5'd13);
    checkOutput("lw_mis_err", r_err_cnt, 1);
    checkOutput("lw_mis_req", r_req_cnt, 0);
    checkOutput("lw_mis_wb", r_wb_cnt, 0);
    checkOutput("lw_mis_latency", r_done, 2);
    checkOutput("lw_mis_after", r_after, 0);

    applyStimulus(1'b0, 1'b1, 3'b001, 32'd1, 32'hFFFF_FFFF, 5'd0);
    checkOutput("sh_mis_err", r_err_cnt, 1);
    checkOutput("sh_mis_req", r_req_cnt, 0);

    applyStimulus(1'b1, 1'b0, 3'b011, 32'd0, 32'h0, 5'd14);
    checkOutput("f3_011_err", r_err_cnt, 1);
    checkOutput("f3_011_req", r_req_cnt, 0);
    checkOutput("f3_011_wb", r_wb_cnt, 0);

    // Reset while waiting for read data; a late rvalid must be discarded.
    rvalid_delay = 5;
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'd0; ex_rd = 5'd15;
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_wait_stall", {31'h0, lsu_stall}, 32'd1);
    checkOutput("rst_wait_noreq", {31'h0, dmem_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    inj_rvalid = 1'b1;
    #1;
    checkOutput("rst_ctrl", {27'h0, lsu_stall, wb_valid, lsu_err, dmem_req, dmem_we}, 32'h0);
    checkOutput("rst_wb", wb_data | {27'h0, wb_rd}, 32'h0);
    checkOutput("rst_mem", {18'h0, dmem_be, dmem_addr} | dmem_wdata, 32'h0);
    @(negedge clk);
    inj_rvalid = 1'b0;
    #1;
    checkOutput("rst_no_wb", {30'h0, wb_valid, lsu_stall}, 32'h0);
    rvalid_delay = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
